// File: rtl/if_id_skid.sv
`default_nettype none
// ============================================================================
// Module   : if_id_skid
// Purpose  : IF/ID boundary with a 2-entry skid buffer, registered ready and flush
// Revision : 1.0
// ============================================================================
module if_id_skid #(
    parameter int                INST_W   = 32,
    parameter int                ADDR_W   = 32,
    parameter int                SIDE_W   = 4,
    parameter logic [INST_W-1:0] NOP      = INST_W'(32'h00000013),
    parameter logic [ADDR_W-1:0] RST_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst_,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [INST_W-1:0] inst_i,
    input  logic [ADDR_W-1:0] inst_addr_i,
    input  logic [SIDE_W-1:0] side_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [INST_W-1:0] inst_o,
    output logic [ADDR_W-1:0] inst_addr_o,
    output logic [SIDE_W-1:0] side_o,
    output logic [1:0]        occupancy_o
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                in_ready_q, in_ready_d;
    logic [INST_W-1:0]   main_inst_q, main_inst_d, skid_inst_q, skid_inst_d;
    logic [ADDR_W-1:0]   main_addr_q, main_addr_d, skid_addr_q, skid_addr_d;
    logic [SIDE_W-1:0]   main_side_q, main_side_d, skid_side_q, skid_side_d;

    logic in_fire;
    logic out_fire;

    assign out_valid_o = (state_q != EMPTY);
    assign in_ready_o  = in_ready_q;
    assign in_fire     = in_valid_i & in_ready_q;
    assign out_fire    = out_valid_o & out_ready_i;

    always_comb begin
        state_d     = state_q;
        main_inst_d = main_inst_q;
        main_addr_d = main_addr_q;
        main_side_d = main_side_q;
        skid_inst_d = skid_inst_q;
        skid_addr_d = skid_addr_q;
        skid_side_d = skid_side_q;

        if (flush_i) begin
            state_d     = EMPTY;
            main_inst_d = NOP;
            main_addr_d = RST_ADDR;
            main_side_d = '0;
            skid_inst_d = NOP;
            skid_addr_d = RST_ADDR;
            skid_side_d = '0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        state_d     = ONE;
                        main_inst_d = inst_i;
                        main_addr_d = inst_addr_i;
                        main_side_d = side_i;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_inst_d = inst_i;
                        main_addr_d = inst_addr_i;
                        main_side_d = side_i;
                    end else if (in_fire) begin
                        state_d     = TWO;
                        skid_inst_d = inst_i;
                        skid_addr_d = inst_addr_i;
                        skid_side_d = side_i;
                    end else if (out_fire) begin
                        state_d     = EMPTY;
                        main_inst_d = NOP;
                        main_addr_d = RST_ADDR;
                        main_side_d = '0;
                    end
                end
                TWO: begin
                    // in_ready is low here, so only a drain can happen
                    if (out_fire) begin
                        state_d     = ONE;
                        main_inst_d = skid_inst_q;
                        main_addr_d = skid_addr_q;
                        main_side_d = skid_side_q;
                        skid_inst_d = NOP;
                        skid_addr_d = RST_ADDR;
                        skid_side_d = '0;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end

        // Ready is derived from next state only, keeping out_ready_i off the upstream path
        in_ready_d = (state_d != TWO);
    end

    always_ff @(posedge clk) begin
        if (!rst_) begin
            state_q     <= EMPTY;
            in_ready_q  <= 1'b1;
            main_inst_q <= NOP;
            main_addr_q <= RST_ADDR;
            main_side_q <= '0;
            skid_inst_q <= NOP;
            skid_addr_q <= RST_ADDR;
            skid_side_q <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            main_inst_q <= main_inst_d;
            main_addr_q <= main_addr_d;
            main_side_q <= main_side_d;
            skid_inst_q <= skid_inst_d;
            skid_addr_q <= skid_addr_d;
            skid_side_q <= skid_side_d;
        end
    end

    assign inst_o      = main_inst_q;
    assign inst_addr_o = main_addr_q;
    assign side_o      = main_side_q;
    assign occupancy_o = state_q;

endmodule
`default_nettype wire
